layer_compositor: RTL and testbench
===================================

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, meaning the number of sprite/tile layers (2..8); layer 0 is the player (bird) layer.
REQ-002 SHALL have parameter COLOR_W, default 12, meaning the pixel width, packed {B,G,R} at 4 bits each.
REQ-003 SHALL have parameter X_W, default 10, meaning the X coordinate width.
REQ-004 SHALL have parameter Y_W, default 9, meaning the Y coordinate width.
REQ-005 vga_clk  in  1  pixel clock; the single clock of the block.
REQ-006 clrn  in  1  reset, asynchronous and active-low.
REQ-007 pix_valid  in  1  the current X_Addr/Y_Addr lies in the visible area.
REQ-008 X_Addr  in  X_W  pixel column.
REQ-009 Y_Addr  in  Y_W  pixel row.
REQ-010 frame_start  in  1  one-cycle pulse at the first pixel of each frame.
REQ-011 layer_en  in  NUM_LAYERS  per-layer enable (mode switches).
REQ-012 layer_hit  in  NUM_LAYERS  the pixel is inside the layer's bounding box.
REQ-013 layer_opaque  in  NUM_LAYERS  the layer's ROM alpha nibble is 4'hF.
REQ-014 layer_rgb  in  NUM_LAYERS*COLOR_W  per-layer colour; layer i occupies bits [i*COLOR_W +: COLOR_W].
REQ-015 bg_rgb  in  COLOR_W  background colour (day/night already selected).
REQ-016 collide_mask  in  NUM_LAYERS  layers counted as obstacles; bit 0 is ignored.
REQ-017 out_rgb  out  COLOR_W  composited pixel.
REQ-018 out_valid  out  1  delayed pix_valid.
REQ-019 out_X / out_Y  out  X_W / Y_W  delayed coordinates.
REQ-020 collide  out  1  per-pixel collision pulse, aligned with out_rgb.
REQ-021 collide_frame  out  1  sticky flag: a collision has occurred in the current frame.
REQ-022 collide_count  out  8  number of frames that contained a collision, saturating.

Function
REQ-023 vis[i] SHALL equal layer_en[i] & layer_hit[i] & layer_opaque[i].
REQ-024 Stage 1 SHALL register vis, layer_rgb, bg_rgb, X_Addr, Y_Addr, pix_valid and frame_start on every vga_clk edge.
REQ-025 Stage 2 SHALL register out_rgb = layer_rgb of the lowest-index set vis bit, or bg_rgb if no vis bit is set.
REQ-026 Latency SHALL be exactly 2 cycles from input to out_rgb/out_valid/out_X/out_Y/collide, with no stalls and one pixel per cycle.
REQ-027 When delayed pix_valid=0, out_rgb SHALL be 0 (blanking) regardless of the layers.
REQ-028 collide SHALL be 1 iff delayed pix_valid & vis[0] & |(vis[NUM_LAYERS-1:1] & collide_mask[NUM_LAYERS-1:1]), evaluated on stage-1 data.
REQ-029 A disabled or transparent layer (vis=0) SHALL never cause a collision.
REQ-030 When delayed frame_start is 1 (stage-2 edge), collide_count SHALL increment if collide_frame=1, holding at 255.
REQ-031 In the same cycle as REQ-030, collide_frame SHALL clear, unless the same cycle's collide=1, in which case it is set; a set takes priority over the clear.
REQ-032 Otherwise, collide_frame SHALL set on collide=1 and otherwise hold.
REQ-033 Changing layer_en mid-frame SHALL take effect on the pixel presented in that cycle, 2 cycles later at the output.

Reset
REQ-034 While clrn=0, all pipeline registers, out_rgb, out_valid, out_X, out_Y, collide, collide_frame and collide_count SHALL be 0, asynchronously.
REQ-035 After release, the first valid output SHALL appear 2 cycles after the first pix_valid=1 sampled.
REQ-036 A reset asserted mid-frame SHALL discard in-flight pixels, with no partial-frame count.

Verification
REQ-037 NUM_LAYERS=4, with layers 1 and 2 both visible (rgb 12'h0C0 and 12'h123) and layer 0 not visible -> out_rgb=12'h0C0 2 cycles later.
REQ-038 Layer 0 visible and layer 1 visible with collide_mask=4'b0010 -> out_rgb=layer0 rgb, collide=1, and collide_frame=1 from the next cycle.
REQ-039 Same as REQ-038 but layer_opaque[1]=0 or collide_mask[1]=0 -> collide=0 and collide_frame stays 0.
REQ-040 Collisions in 3 consecutive frames followed by a clean frame -> collide_count=3 after the 4th frame_start and collide_frame=0; preloading 255 -> count stays 255.
REQ-041 frame_start coincident with a colliding pixel -> collide_frame=1 after that edge and the count increments on the previous frame's flag.
REQ-042 Assert clrn low mid-line with pix_valid=1 -> all outputs 0 immediately; after release, outputs are 0 until 2 cycles after pix_valid.

Source files
------------

// File: rtl/layer_compositor.sv
// Two-stage layer compositor: lowest-index visible layer wins over the background,
// with per-pixel bird/obstacle collision detection and per-frame collision counting.
module layer_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 12,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic                          vga_clk,
    input  logic                          clrn,
    input  logic                          pix_valid,
    input  logic [X_W-1:0]                X_Addr,
    input  logic [Y_W-1:0]                Y_Addr,
    input  logic                          frame_start,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [NUM_LAYERS-1:0]         layer_hit,
    input  logic [NUM_LAYERS-1:0]         layer_opaque,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [COLOR_W-1:0]            bg_rgb,
    input  logic [NUM_LAYERS-1:0]         collide_mask,
    output logic [COLOR_W-1:0]            out_rgb,
    output logic                          out_valid,
    output logic [X_W-1:0]                out_X,
    output logic [Y_W-1:0]                out_Y,
    output logic                          collide,
    output logic                          collide_frame,
    output logic [7:0]                    collide_count
);

    logic [NUM_LAYERS-1:0]         vis_q;
    logic [NUM_LAYERS-1:1]         mask_q;
    logic [NUM_LAYERS*COLOR_W-1:0] rgb_q;
    logic [COLOR_W-1:0]            bg_q;
    logic [X_W-1:0]                x_q;
    logic [Y_W-1:0]                y_q;
    logic                          valid_q;
    logic                          fs_q;

    logic [COLOR_W-1:0]            sel_rgb;
    logic                          collide_d;

    // Stage 1: capture the pixel and its per-layer visibility.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            vis_q   <= '0;
            mask_q  <= '0;
            rgb_q   <= '0;
            bg_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            vis_q   <= layer_en & layer_hit & layer_opaque;
            mask_q  <= collide_mask[NUM_LAYERS-1:1];
            rgb_q   <= layer_rgb;
            bg_q    <= bg_rgb;
            x_q     <= X_Addr;
            y_q     <= Y_Addr;
            valid_q <= pix_valid;
            fs_q    <= frame_start;
        end
    end

    // Scan from the top layer down so the lowest visible index is assigned last.
    always_comb begin
        sel_rgb = bg_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vis_q[i]) sel_rgb = rgb_q[i*COLOR_W +: COLOR_W];
        end
    end

    assign collide_d = valid_q & vis_q[0] & (|(vis_q[NUM_LAYERS-1:1] & mask_q));

    // Stage 2: outputs plus frame-level collision bookkeeping.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            out_rgb       <= '0;
            out_valid     <= 1'b0;
            out_X         <= '0;
            out_Y         <= '0;
            collide       <= 1'b0;
            collide_frame <= 1'b0;
            collide_count <= 8'd0;
        end else begin
            out_rgb   <= valid_q ? sel_rgb : '0;
            out_valid <= valid_q;
            out_X     <= x_q;
            out_Y     <= y_q;
            collide   <= collide_d;
            if (fs_q) begin
                // Count closes out the previous frame; the flag restarts with this pixel.
                if (collide_frame && (collide_count != 8'hFF)) begin
                    collide_count <= collide_count + 8'd1;
                end
                collide_frame <= collide_d;
            end else if (collide_d) begin
                collide_frame <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority, blanking, collisions, frame counting, reset.
module tb_layer_compositor;

    localparam int NL = 4;
    localparam int CW = 12;

    logic           vga_clk = 1'b0;
    logic           clrn;
    logic           pix_valid;
    logic [9:0]     X_Addr;
    logic [8:0]     Y_Addr;
    logic           frame_start;
    logic [NL-1:0]  layer_en, layer_hit, layer_opaque, collide_mask;
    logic [NL*CW-1:0] layer_rgb;
    logic [CW-1:0]  bg_rgb;
    logic [CW-1:0]  out_rgb;
    logic           out_valid;
    logic [9:0]     out_X;
    logic [8:0]     out_Y;
    logic           collide, collide_frame;
    logic [7:0]     collide_count;

    int errors = 0;
    int checks = 0;

    layer_compositor #(.NUM_LAYERS(NL), .COLOR_W(CW), .X_W(10), .Y_W(9)) dut (
        .vga_clk      (vga_clk),
        .clrn         (clrn),
        .pix_valid    (pix_valid),
        .X_Addr       (X_Addr),
        .Y_Addr       (Y_Addr),
        .frame_start  (frame_start),
        .layer_en     (layer_en),
        .layer_hit    (layer_hit),
        .layer_opaque (layer_opaque),
        .layer_rgb    (layer_rgb),
        .bg_rgb       (bg_rgb),
        .collide_mask (collide_mask),
        .out_rgb      (out_rgb),
        .out_valid    (out_valid),
        .out_X        (out_X),
        .out_Y        (out_Y),
        .collide      (collide),
        .collide_frame(collide_frame),
        .collide_count(collide_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] en, input logic [3:0] hit,
                         input logic [3:0] opq, input logic [3:0] mask, input logic fs);
        pix_valid    = v;
        layer_en     = en;
        layer_hit    = hit;
        layer_opaque = opq;
        collide_mask = mask;
        frame_start  = fs;
    endtask

    task automatic idle();
        pix_valid   = 1'b0;
        layer_hit   = 4'b0000;
        frame_start = 1'b0;
    endtask

    // One pixel followed by a blank, leaving its result on the outputs.
    task automatic pixel(input logic v, input logic [3:0] en, input logic [3:0] hit,
                         input logic [3:0] opq, input logic [3:0] mask, input logic fs);
        drive(v, en, hit, opq, mask, fs);
        step();
        idle();
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rgb"}, 32'(out_rgb), 32'h0);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_x"}, 32'(out_X), 32'h0);
        check({tag, "_y"}, 32'(out_Y), 32'h0);
        check({tag, "_collide"}, 32'(collide), 32'h0);
        check({tag, "_frame"}, 32'(collide_frame), 32'h0);
        check({tag, "_count"}, 32'(collide_count), 32'h0);
    endtask

    initial begin
        clrn      = 1'b1;
        X_Addr    = 10'd0;
        Y_Addr    = 9'd0;
        layer_rgb = {12'hABC, 12'h123, 12'h0C0, 12'hFFF};
        bg_rgb    = 12'h5A5;
        drive(1'b1, 4'hF, 4'hF, 4'hF, 4'b0010, 1'b1);
        #2 clrn = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        step();
        check_all_zero("reset_held");

        idle();
        #2 clrn = 1'b1;
        step();

        // Blanking: everything visible but pix_valid low.
        pixel(1'b0, 4'hF, 4'hF, 4'hF, 4'b0010, 1'b0);
        check("blank_rgb", 32'(out_rgb), 32'h0);
        check("blank_collide", 32'(collide), 32'h0);

        // Layers 1 and 2 visible, layer 0 not: layer 1 wins; latency is two edges.
        X_Addr = 10'd5;
        Y_Addr = 9'd7;
        drive(1'b1, 4'hF, 4'b0110, 4'hF, 4'b0010, 1'b0);
        step();
        check("latency_valid_early", 32'(out_valid), 32'h0);
        idle();
        step();
        check("prio_rgb", 32'(out_rgb), 32'h0C0);
        check("prio_valid", 32'(out_valid), 32'h1);
        check("prio_x", 32'(out_X), 32'd5);
        check("prio_y", 32'(out_Y), 32'd7);
        check("prio_collide", 32'(collide), 32'h0);

        pixel(1'b1, 4'hF, 4'b0000, 4'hF, 4'b0010, 1'b0);
        check("bg_rgb", 32'(out_rgb), 32'h5A5);

        // Layer 1 transparent: no collision.
        pixel(1'b1, 4'hF, 4'b0011, 4'b1101, 4'b0010, 1'b0);
        check("transp_rgb", 32'(out_rgb), 32'hFFF);
        check("transp_collide", 32'(collide), 32'h0);
        check("transp_frame", 32'(collide_frame), 32'h0);

        // Layer 1 not in the mask (bit 0 set, must be ignored): no collision.
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b1101, 1'b0);
        check("nomask_collide", 32'(collide), 32'h0);
        check("nomask_frame", 32'(collide_frame), 32'h0);

        // Layer 1 disabled: no collision.
        pixel(1'b1, 4'b1101, 4'b0011, 4'hF, 4'b0010, 1'b0);
        check("disabled_collide", 32'(collide), 32'h0);

        // Back-to-back pixels with layer_en changing between them.
        drive(1'b1, 4'hF, 4'b0110, 4'hF, 4'b0010, 1'b0);
        step();
        drive(1'b1, 4'b1101, 4'b0110, 4'hF, 4'b0010, 1'b0);
        step();
        check("en_change_a", 32'(out_rgb), 32'h0C0);
        idle();
        step();
        check("en_change_b", 32'(out_rgb), 32'h123);

        // Bird over obstacle layer 1: collision (frame 1).
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b0);
        check("hit_rgb", 32'(out_rgb), 32'hFFF);
        check("hit_collide", 32'(collide), 32'h1);
        check("hit_frame", 32'(collide_frame), 32'h1);
        step();
        check("hit_pulse_end", 32'(collide), 32'h0);
        check("hit_frame_sticky", 32'(collide_frame), 32'h1);

        // Frames 2 and 3 also collide; frame 4 is clean.
        pixel(1'b1, 4'hF, 4'b0000, 4'hF, 4'b0010, 1'b1);
        check("frame2_count", 32'(collide_count), 32'd1);
        check("frame2_flag_clear", 32'(collide_frame), 32'h0);
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b0);
        pixel(1'b1, 4'hF, 4'b0000, 4'hF, 4'b0010, 1'b1);
        check("frame3_count", 32'(collide_count), 32'd2);
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b0);
        pixel(1'b1, 4'hF, 4'b0000, 4'hF, 4'b0010, 1'b1);
        check("frame4_count", 32'(collide_count), 32'd3);
        check("frame4_flag", 32'(collide_frame), 32'h0);

        // frame_start coincident with a colliding pixel.
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b0);
        pixel(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b1);
        check("fs_hit_count", 32'(collide_count), 32'd4);
        check("fs_hit_flag", 32'(collide_frame), 32'h1);
        check("fs_hit_collide", 32'(collide), 32'h1);
        pixel(1'b1, 4'hF, 4'b0000, 4'hF, 4'b0010, 1'b1);
        check("fs_clean_count", 32'(collide_count), 32'd5);
        check("fs_clean_flag", 32'(collide_frame), 32'h0);

        // Every cycle a colliding one-pixel frame: the count must saturate.
        drive(1'b1, 4'hF, 4'b0011, 4'hF, 4'b0010, 1'b1);
        repeat (300) step();
        check("sat_count", 32'(collide_count), 32'd255);
        idle();
        step();
        step();
        check("sat_hold", 32'(collide_count), 32'd255);

        // Reset mid-line with a valid pixel in flight.
        X_Addr = 10'd9;
        Y_Addr = 9'd3;
        drive(1'b1, 4'hF, 4'b0110, 4'hF, 4'b0010, 1'b0);
        step();
        step();
        check("midline_valid", 32'(out_valid), 32'h1);
        #2 clrn = 1'b0;
        #1 check_all_zero("midline_reset");
        step();
        check("midline_held_valid", 32'(out_valid), 32'h0);
        idle();
        #2 clrn = 1'b1;
        step();
        step();
        check("post_rst_valid", 32'(out_valid), 32'h0);
        check("post_rst_rgb", 32'(out_rgb), 32'h0);
        drive(1'b1, 4'hF, 4'b0110, 4'hF, 4'b0010, 1'b0);
        step();
        check("post_rst_latency", 32'(out_valid), 32'h0);
        idle();
        step();
        check("post_rst_first_valid", 32'(out_valid), 32'h1);
        check("post_rst_first_rgb", 32'(out_rgb), 32'h0C0);
        check("post_rst_count", 32'(collide_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
